// File: rtl/svo_vdma_pkg.sv
// Shared types and register map for the video DMA flip controller.
package svo_vdma_pkg;

    typedef enum logic [2:0] {
        FREE,
        WRITING,
        READY,
        PENDING,
        DISPLAYING
    } buf_state_t;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RESP,
        ARM
    } fsm_state_t;

    localparam logic [7:0] REG_START  = 8'h00;
    localparam logic [7:0] REG_ACTIVE = 8'h04;
    localparam logic [7:0] REG_RES    = 8'h08;
    localparam logic [7:0] REG_TERM   = 8'h0C;

    function automatic logic [31:0] buf_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [1:0]  idx);
        return base + ({30'd0, idx} * stride);
    endfunction

endpackage

// File: rtl/svo_vdma_flipctl_if.sv
// AXI4-lite write channel toward the DMA configuration port.
interface svo_vdma_flipctl_if;
    logic        awvalid;
    logic        awready;
    logic [7:0]  awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic        bvalid;
    logic        bready;

    modport master (output awvalid, awaddr, wvalid, wdata, bready,
                    input  awready, wready, bvalid);
    modport slave  (input  awvalid, awaddr, wvalid, wdata, bready,
                    output awready, wready, bvalid);
endinterface

// File: rtl/svo_vdma_flipctl_axilw.sv
// Single-outstanding AXI4-lite write master; address and data are issued together.
module svo_vdma_flipctl_axilw (
    input  logic        oclk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  addr,
    input  logic [31:0] data,
    output logic        done,
    svo_vdma_flipctl_if.master cfg
);

    always_ff @(posedge oclk) begin
        if (!resetn) begin
            cfg.awvalid <= 1'b0;
            cfg.wvalid  <= 1'b0;
            cfg.bready  <= 1'b0;
            cfg.awaddr  <= '0;
            cfg.wdata   <= '0;
        end else if (start && !cfg.awvalid && !cfg.bready) begin
            cfg.awvalid <= 1'b1;
            cfg.wvalid  <= 1'b1;
            cfg.awaddr  <= addr;
            cfg.wdata   <= data;
        end else if (cfg.awvalid && cfg.awready && cfg.wready) begin
            // The DMA accepts address and data in the same beat.
            cfg.awvalid <= 1'b0;
            cfg.wvalid  <= 1'b0;
            cfg.bready  <= 1'b1;
        end else if (cfg.bready && cfg.bvalid) begin
            cfg.bready  <= 1'b0;
        end
    end

    assign done = cfg.bready && cfg.bvalid;

endmodule

// File: rtl/svo_vdma_flipctl.sv
// Framebuffer flip controller: hands buffers to a renderer and retires them on SOF beats.
module svo_vdma_flipctl
    import svo_vdma_pkg::*;
#(
    parameter int          NUM_BUFFERS = 3,
    parameter logic [31:0] BUF_BASE    = 32'h1000_0000,
    parameter logic [31:0] BUF_STRIDE  = 32'h0040_0000,
    parameter int          SOF_LAG     = 2
) (
    input  logic        oclk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        acq_valid,
    output logic        acq_ready,
    output logic [1:0]  acq_index,
    output logic [31:0] acq_addr,
    input  logic        sub_valid,
    output logic        sub_ready,
    input  logic        mon_tvalid,
    input  logic        mon_tready,
    input  logic        mon_tuser,
    svo_vdma_flipctl_if.master cfg,
    output logic [1:0]  disp_index,
    output logic [15:0] flip_count,
    output logic [15:0] drop_count
);

    localparam logic [7:0] LAG       = 8'(SOF_LAG);
    localparam logic [3:0] QUIET_MAX = 4'hF;

    fsm_state_t  state, state_nx;
    buf_state_t  bstate [4];
    buf_state_t  bstate_nx [4];
    logic        enable_q, blank_req, wr_blank, wr_blank_nx;
    logic [7:0]  sof_cnt;
    logic [3:0]  quiet_cnt;
    logic        has_free, has_writing, has_ready, has_pending;
    logic [1:0]  free_idx, wr_idx, rdy_idx, pend_idx;
    logic        start, done, accepted, arm_exit, flip, blank_done, drop, take_ready;
    logic        acq_fire, sub_fire, rise, fall, beat;
    logic [31:0] wr_data;

    // Descending scan so the lowest-index FREE buffer wins.
    always_comb begin
        has_free = 1'b0; has_writing = 1'b0; has_ready = 1'b0; has_pending = 1'b0;
        free_idx = '0;   wr_idx = '0;        rdy_idx = '0;     pend_idx = '0;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            case (bstate[i])
                FREE:    begin has_free    = 1'b1; free_idx = 2'(i); end
                WRITING: begin has_writing = 1'b1; wr_idx   = 2'(i); end
                READY:   begin has_ready   = 1'b1; rdy_idx  = 2'(i); end
                PENDING: begin has_pending = 1'b1; pend_idx = 2'(i); end
                default: ;
            endcase
        end
    end

    assign rise      = enable && !enable_q;
    assign fall      = !enable && enable_q;
    assign acq_ready = enable && enable_q && !has_writing && has_free;
    assign acq_index = free_idx;
    assign acq_addr  = buf_addr(BUF_BASE, BUF_STRIDE, free_idx);
    assign sub_ready = has_writing;
    assign acq_fire  = acq_valid && acq_ready;
    assign sub_fire  = sub_valid && sub_ready;
    assign beat      = mon_tvalid && mon_tready && mon_tuser;
    assign accepted  = cfg.awvalid && cfg.awready && cfg.wready;
    // A blanked DMA may stop streaming, so a long quiet spell also ends the blank wait.
    assign arm_exit  = (sof_cnt == LAG) || (wr_blank && quiet_cnt == QUIET_MAX);

    always_comb begin
        state_nx    = state;
        bstate_nx   = bstate;
        wr_blank_nx = wr_blank;
        start       = 1'b0;
        wr_data     = '0;
        take_ready  = 1'b0;
        flip        = 1'b0;
        blank_done  = 1'b0;
        drop        = 1'b0;
        case (state)
            IDLE: begin
                if (blank_req) begin
                    start       = 1'b1;
                    wr_blank_nx = 1'b1;
                    state_nx    = WR;
                end else if (enable && has_ready && !has_pending) begin
                    start              = 1'b1;
                    wr_blank_nx        = 1'b0;
                    wr_data            = buf_addr(BUF_BASE, BUF_STRIDE, rdy_idx);
                    take_ready         = 1'b1;
                    bstate_nx[rdy_idx] = PENDING;
                    state_nx           = WR;
                end
            end
            WR:   if (accepted) state_nx = RESP;
            RESP: if (done) state_nx = ARM;
            ARM: begin
                if (arm_exit) begin
                    state_nx   = IDLE;
                    flip       = !wr_blank;
                    blank_done = wr_blank;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (flip) begin
            for (int i = 0; i < NUM_BUFFERS; i++)
                if (bstate[i] == DISPLAYING) bstate_nx[i] = FREE;
            bstate_nx[pend_idx] = DISPLAYING;
        end
        if (blank_done) begin
            for (int i = 0; i < NUM_BUFFERS; i++)
                if (bstate[i] != WRITING && !(bstate[i] == READY && enable))
                    bstate_nx[i] = FREE;
        end
        if (acq_fire) bstate_nx[free_idx] = WRITING;
        if (sub_fire) begin
            if (enable) begin
                if (has_ready && !take_ready) begin
                    bstate_nx[rdy_idx] = FREE;
                    drop               = 1'b1;
                end
                bstate_nx[wr_idx] = READY;
            end else begin
                bstate_nx[wr_idx] = FREE;
            end
        end
        if (rise && !has_ready && has_free && !sub_fire) bstate_nx[free_idx] = READY;
    end

    always_ff @(posedge oclk) begin
        if (!resetn) begin
            state      <= IDLE;
            for (int i = 0; i < 4; i++) bstate[i] <= FREE;
            enable_q   <= 1'b0;
            blank_req  <= 1'b0;
            wr_blank   <= 1'b0;
            sof_cnt    <= '0;
            quiet_cnt  <= '0;
            disp_index <= '0;
            flip_count <= '0;
            drop_count <= '0;
        end else begin
            state    <= state_nx;
            bstate   <= bstate_nx;
            enable_q <= enable;
            wr_blank <= wr_blank_nx;
            if (fall)                            blank_req <= 1'b1;
            else if (rise || (start && blank_req)) blank_req <= 1'b0;
            // SOF beats coincident with the write response are not counted.
            if (state == RESP) begin
                sof_cnt   <= '0;
                quiet_cnt <= '0;
            end else if (state == ARM) begin
                if (beat && sof_cnt != LAG) sof_cnt <= sof_cnt + 8'd1;
                if (mon_tvalid)              quiet_cnt <= '0;
                else if (quiet_cnt != QUIET_MAX) quiet_cnt <= quiet_cnt + 4'd1;
            end
            if (flip) begin
                disp_index <= pend_idx;
                flip_count <= flip_count + 16'd1;
            end
            if (drop) drop_count <= drop_count + 16'd1;
        end
    end

    svo_vdma_flipctl_axilw u_axilw (
        .oclk   (oclk),
        .resetn (resetn),
        .start  (start),
        .addr   (REG_START),
        .data   (wr_data),
        .done   (done),
        .cfg    (cfg)
    );

endmodule

// File: tb/tb_svo_vdma_flipctl.sv
// Directed bench for the flip controller: a 3-buffer unit with a controllable DMA and a 2-buffer unit.
module tb_svo_vdma_flipctl;

    logic        oclk = 1'b0;
    logic        resetn, enable, enable2;
    logic        acq_valid, sub_valid, acq_valid2, sub_valid2;
    logic        mon_tvalid, mon_tready, mon_tuser;
    logic        dma_rdy;
    logic        acq_ready, sub_ready, acq_ready2, sub_ready2;
    logic [1:0]  acq_index, disp_index, acq_index2, disp_index2;
    logic [31:0] acq_addr, acq_addr2;
    logic [15:0] flip_count, drop_count, flip_count2, drop_count2;
    int          vectors = 0;
    int          miscompares = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_last = '0;

    svo_vdma_flipctl_if cfg ();
    svo_vdma_flipctl_if cfg2 ();

    always #5 oclk = ~oclk;

    // DMA models: response follows bready immediately.
    assign cfg.awready  = dma_rdy;
    assign cfg.wready   = dma_rdy;
    assign cfg.bvalid   = cfg.bready;
    assign cfg2.awready = 1'b1;
    assign cfg2.wready  = 1'b1;
    assign cfg2.bvalid  = cfg2.bready;

    always @(posedge oclk)
        if (cfg.awvalid && cfg.awready && cfg.wready) begin
            wr_cnt  <= wr_cnt + 1;
            wr_last <= cfg.wdata;
        end

    svo_vdma_flipctl #(.NUM_BUFFERS(3)) u_dut (
        .oclk(oclk), .resetn(resetn), .enable(enable),
        .acq_valid(acq_valid), .acq_ready(acq_ready), .acq_index(acq_index), .acq_addr(acq_addr),
        .sub_valid(sub_valid), .sub_ready(sub_ready),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tuser(mon_tuser),
        .cfg(cfg), .disp_index(disp_index), .flip_count(flip_count), .drop_count(drop_count)
    );

    svo_vdma_flipctl #(.NUM_BUFFERS(2)) u_dut2 (
        .oclk(oclk), .resetn(resetn), .enable(enable2),
        .acq_valid(acq_valid2), .acq_ready(acq_ready2), .acq_index(acq_index2), .acq_addr(acq_addr2),
        .sub_valid(sub_valid2), .sub_ready(sub_ready2),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tuser(mon_tuser),
        .cfg(cfg2), .disp_index(disp_index2), .flip_count(flip_count2), .drop_count(drop_count2)
    );

    task automatic step();
        @(posedge oclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sof(input int n);
        for (int k = 0; k < n; k++) begin
            step(); step();
            mon_tuser = 1'b1;
            step();
            mon_tuser = 1'b0;
        end
    endtask

    task automatic wait_wr(input int n, input logic [31:0] exp_data, input string tag);
        for (int k = 0; k < 60 && wr_cnt < n; k++) step();
        chk({tag, "_count"}, 32'(wr_cnt), 32'(n));
        chk({tag, "_data"}, wr_last, exp_data);
    endtask

    task automatic wait_aw(input string tag);
        for (int k = 0; k < 20 && !cfg.awvalid; k++) step();
        chk(tag, {31'd0, cfg.awvalid}, 32'd1);
    endtask

    task automatic acquire();
        acq_valid = 1'b1; step(); acq_valid = 1'b0;
    endtask

    task automatic submit();
        sub_valid = 1'b1; step(); sub_valid = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_acq_ready"},   {31'd0, acq_ready},   32'd0);
        chk({tag, "_sub_ready"},   {31'd0, sub_ready},   32'd0);
        chk({tag, "_awvalid"},     {31'd0, cfg.awvalid}, 32'd0);
        chk({tag, "_wvalid"},      {31'd0, cfg.wvalid},  32'd0);
        chk({tag, "_bready"},      {31'd0, cfg.bready},  32'd0);
        chk({tag, "_disp_index"},  {30'd0, disp_index},  32'd0);
        chk({tag, "_flip_count"},  {16'd0, flip_count},  32'd0);
        chk({tag, "_drop_count"},  {16'd0, drop_count},  32'd0);
        chk({tag, "_acq_index"},   {30'd0, acq_index},   32'd0);
        chk({tag, "_awaddr"},      {24'd0, cfg.awaddr},  32'd0);
        chk({tag, "_wdata"},       cfg.wdata,            32'd0);
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0; enable2 = 1'b0;
        acq_valid = 1'b0; sub_valid = 1'b0; acq_valid2 = 1'b0; sub_valid2 = 1'b0;
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tuser = 1'b0; dma_rdy = 1'b1;
        repeat (3) step();
        reset_checks("rst");

        // Bring-up: buffer 0 is shown without any acquire.
        resetn = 1'b1; enable = 1'b1;
        wait_wr(1, 32'h1000_0000, "boot_wr");
        sof(1); step(); step();
        chk("boot_lag_flip", {16'd0, flip_count}, 32'd0);
        sof(1); step(); step();
        chk("boot_flip", {16'd0, flip_count}, 32'd1);
        chk("boot_disp", {30'd0, disp_index}, 32'd0);

        // Normal flip to buffer 1.
        chk("acq1_ready", {31'd0, acq_ready}, 32'd1);
        chk("acq1_index", {30'd0, acq_index}, 32'd1);
        chk("acq1_addr", acq_addr, 32'h1040_0000);
        acquire();
        chk("acq1_sub_ready", {31'd0, sub_ready}, 32'd1);
        chk("acq1_busy", {31'd0, acq_ready}, 32'd0);
        submit();
        wait_wr(2, 32'h1040_0000, "flip1_wr");
        sof(2); step(); step();
        chk("flip1_disp", {30'd0, disp_index}, 32'd1);
        chk("flip1_count", {16'd0, flip_count}, 32'd2);
        chk("flip1_free0", {30'd0, acq_index}, 32'd0);

        // Back-pressure: the DMA stalls for 10 cycles.
        dma_rdy = 1'b0;
        acquire(); submit();
        wait_aw("bp_aw_up");
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_awvalid", {31'd0, cfg.awvalid}, 32'd1);
            chk("bp_wvalid", {31'd0, cfg.wvalid}, 32'd1);
            chk("bp_wdata", cfg.wdata, 32'h1000_0000);
            chk("bp_awaddr", {24'd0, cfg.awaddr}, 32'd0);
            chk("bp_no_write", 32'(wr_cnt), 32'd2);
        end
        dma_rdy = 1'b1;
        wait_wr(3, 32'h1000_0000, "bp_wr");
        sof(2); step(); step();
        chk("bp_disp", {30'd0, disp_index}, 32'd0);
        chk("bp_flip", {16'd0, flip_count}, 32'd3);
        chk("bp_single_write", 32'(wr_cnt), 32'd3);

        // Disable while buffer 1 is being rendered.
        chk("dis_acq_index", {30'd0, acq_index}, 32'd1);
        acquire();
        enable = 1'b0;
        wait_wr(4, 32'h0000_0000, "blank_wr");
        sof(2); step(); step();
        chk("blank_flip_kept", {16'd0, flip_count}, 32'd3);
        chk("blank_writing_kept", {31'd0, sub_ready}, 32'd1);
        chk("blank_acq_off", {31'd0, acq_ready}, 32'd0);
        submit();
        chk("blank_sub_freed", {31'd0, sub_ready}, 32'd0);

        // Re-enable: buffer 0 boots again, everything else must be free.
        enable = 1'b1;
        wait_wr(5, 32'h1000_0000, "reboot_wr");
        chk("reboot_acq_ready", {31'd0, acq_ready}, 32'd1);
        chk("reboot_acq_index", {30'd0, acq_index}, 32'd1);

        // Drop: buffer 1 is superseded by buffer 2 while buffer 0 is pending.
        acquire(); submit();
        chk("drop_acq_index", {30'd0, acq_index}, 32'd2);
        chk("drop_acq_addr", acq_addr, 32'h1080_0000);
        acquire(); submit();
        chk("drop_count", {16'd0, drop_count}, 32'd1);
        chk("drop_freed1", {30'd0, acq_index}, 32'd1);
        chk("drop_pending_kept", 32'(wr_cnt), 32'd5);
        sof(2); step(); step();
        chk("drop_flip0_disp", {30'd0, disp_index}, 32'd0);
        chk("drop_flip0_count", {16'd0, flip_count}, 32'd4);
        wait_wr(6, 32'h1080_0000, "drop_wr2");
        sof(2); step(); step();
        chk("drop_flip2_disp", {30'd0, disp_index}, 32'd2);
        chk("drop_flip2_count", {16'd0, flip_count}, 32'd5);

        // Exhaustion on the 2-buffer unit.
        enable2 = 1'b1;
        repeat (6) step();
        sof(2); step(); step();
        chk("ex_boot_flip", {16'd0, flip_count2}, 32'd1);
        chk("ex_acq_ready", {31'd0, acq_ready2}, 32'd1);
        chk("ex_acq_index", {30'd0, acq_index2}, 32'd1);
        acq_valid2 = 1'b1; step(); acq_valid2 = 1'b0;
        chk("ex_sub_ready", {31'd0, sub_ready2}, 32'd1);
        sub_valid2 = 1'b1; step(); sub_valid2 = 1'b0;
        repeat (6) step();
        chk("ex_full", {31'd0, acq_ready2}, 32'd0);
        sof(1); step(); step();
        chk("ex_full_lag", {31'd0, acq_ready2}, 32'd0);
        sof(1); step(); step();
        chk("ex_freed", {31'd0, acq_ready2}, 32'd1);
        chk("ex_freed_index", {30'd0, acq_index2}, 32'd0);
        chk("ex_freed_addr", acq_addr2, 32'h1000_0000);
        chk("ex_disp", {30'd0, disp_index2}, 32'd1);
        chk("ex_flip", {16'd0, flip_count2}, 32'd2);
        chk("ex_drop", {16'd0, drop_count2}, 32'd0);

        // Reset while the write is stalled in WR.
        dma_rdy = 1'b0;
        acquire(); submit();
        wait_aw("rstwr_aw_up");
        resetn = 1'b0;
        step();
        reset_checks("rstwr");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/svo_vdma_flipctl.md
# svo_vdma_flipctl

Frame-buffer flip controller for the video DMA. It owns NUM_BUFFERS framebuffers and hands free ones to a renderer through an acquire/submit handshake. It programs the DMA start-address register (offset 0x00) through an AXI4-lite write master and retires buffers by counting start-of-frame beats tapped from the DMA output stream. The block runs entirely in the oclk (pixel) domain; an AXI clock converter bridges to the DMA config port when the DMA config clock differs.

## Interface
- NUM_BUFFERS, 3: framebuffer count, legal 2..4.
- BUF_BASE, 32'h1000_0000: address of buffer 0; must be nonzero.
- BUF_STRIDE, 32'h0040_0000: byte distance between buffers.
- SOF_LAG, 2: start-of-frame beats after the write response before the new buffer counts as displayed.

- oclk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- enable  in  1  level; 1 = scan out buffers, 0 = blank (start address 0)
- acq_valid / acq_ready  in / out  1 / 1  renderer requests a free buffer
- acq_index / acq_addr  out  2 / 32  granted buffer; valid while acq_ready
- sub_valid / sub_ready  in / out  1 / 1  renderer finished the buffer it holds
- mon_tvalid, mon_tready, mon_tuser  in  1 each  passive tap of the DMA output stream
- cfg_awvalid / cfg_awready / cfg_awaddr  out / in / out  1 / 1 / 8  AXI-lite write address
- cfg_wvalid / cfg_wready / cfg_wdata  out / in / out  1 / 1 / 32  AXI-lite write data
- cfg_bvalid / cfg_bready  in / out  1 / 1  AXI-lite write response
- disp_index  out  2  buffer currently scanned out
- flip_count / drop_count  out  16 / 16  completed flips / superseded frames; both wrap

## Operation
- Each buffer is in one of five states: FREE, WRITING, READY, PENDING, DISPLAYING. At most one buffer is WRITING, one READY, one PENDING and one DISPLAYING.
- Acquire:
  - acq_ready = enable && no buffer WRITING && at least one FREE buffer.
  - acq_index is the lowest-index FREE buffer.
  - acq_addr = BUF_BASE + acq_index*BUF_STRIDE.
  - Handshake moves that buffer to WRITING.
- Submit:
  - sub_ready = 1 exactly when a buffer is WRITING.
  - Handshake moves the WRITING buffer to READY.
  - If a buffer was already READY, that older buffer moves to FREE and drop_count increments (latest frame wins).
- Write engine FSM:
  - IDLE -> WR when enable, a buffer is READY and none is PENDING. The READY buffer moves to PENDING; data = its address.
  - WR -> RESP on awready && wready.
  - RESP -> ARM on cfg_bvalid; clear sof_cnt.
  - In ARM, each beat with mon_tvalid && mon_tready && mon_tuser increments sof_cnt.
  - ARM -> IDLE when sof_cnt reaches SOF_LAG. The PENDING buffer moves to DISPLAYING, the old DISPLAYING buffer moves to FREE, disp_index updates and flip_count increments.
- Enable rise (from reset or from blank): buffer 0 is placed directly in READY with no acquire needed. It flows through the FSM, so the first display is buffer 0.
- Enable fall:
  - Once the FSM is in IDLE, it issues one write of data 0. This uses the same WR/RESP/ARM path; SOF_LAG applies only if the stream is running.
  - After that, every buffer except WRITING moves to FREE.
  - The WRITING buffer stays until it is submitted and is then freed.
- cfg_awaddr is always 8'h00; byte strobes are not driven (write is full-word).

## Timing
- Reset values:
  - acq_ready, sub_ready, cfg_awvalid, cfg_wvalid, cfg_bready: 0.
  - disp_index, flip_count, drop_count, acq_index: 0.
  - cfg_awaddr, cfg_wdata: 0.
  - All buffers FREE; FSM in IDLE.
- acq_ready and sub_ready are combinational from registered state; a handshake takes effect at the next edge.
- cfg_awvalid and cfg_wvalid rise together in the cycle after entering WR and hold, with stable awaddr/wdata, until accepted. The DMA asserts awready and wready together.
- cfg_bready = 1 only in RESP.
- Latency from submit to write issue is at most 1 cycle when the FSM is IDLE.
- An SOF beat coincident with cfg_bvalid is not counted.
- A submit during WR/RESP/ARM replaces the READY buffer only; PENDING is never pre-empted.
- Reset mid-write drops the valids on the next edge. This is legal because the DMA shares resetn.

## Structure
- Shared package svo_vdma_pkg holds:
  - the buffer-state enum (FREE..DISPLAYING);
  - the FSM state enum (IDLE, WR, RESP, ARM);
  - the DMA register offsets: START 8'h00, ACTIVE 8'h04, RES 8'h08, TERM 8'h0C.
- One sub-module, svo_vdma_flipctl_axilw: a single-outstanding AXI-lite write master with ports start/addr/data in and done out.

## Test plan
- **Bring-up:** Reset, then enable=1 with the DMA model acking immediately. Required: one write with data 0x1000_0000, then 2 SOF beats, then disp_index=0 and flip_count=1.
- **Normal flip:** Acquire, giving index 1 and addr 0x1040_0000. Submit it. Required: write of 0x1040_0000 issued; after 2 SOF beats disp_index=1 and buffer 0 FREE again.
- **Drop:**
  - Acquire 1, submit, acquire 2, submit while the write for 1 is in ARM; then acquire 0, submit.
  - Required: buffer 2 superseded, drop_count=1; after the flip to 1 completes, a write of 0x1000_0000 follows.
- **Exhaustion:** With NUM_BUFFERS=2 and one buffer PENDING, plus one DISPLAYING. Required: acq_ready=0 until the flip completes, then 1 with index 0.
- **Back-pressure:** awready and wready held low for 10 cycles. Required: valids held, wdata stable, no second write issued.
- **Disable / reset:**
  - Deassert enable while a buffer is WRITING. Required: a write of data 0, and all other buffers FREE afterwards.
  - Assert resetn=0 during WR. Required: all outputs at their reset values on the next edge.
